// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive control unit.
//   rx_state_t : receive sequencer states
//   half_bit() : timer value (plus one) at which the start bit is re-sampled
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    CHECK = 3'd4
  } rx_state_t;

  // Integer half of a bit period; the start bit is sampled when the timer reaches half_bit-1.
  function automatic int unsigned half_bit(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Wrapping bit-period counter for the UART receiver.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clr_i       : synchronous clear to 0 (has priority over en_i)
//   en_i        : count enable; counts 0..ClksPerBit-1 and wraps
//   rollover_o  : count is at ClksPerBit-1 (end of a bit period)
//   half_o      : count is at ClksPerBit/2-1 (middle of a bit period)
module rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int unsigned ClksPerBit = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic rollover_o,
  output logic half_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = rollover_o ? '0 : count_q + 1'b1;
    end
  end

  assign rollover_o = (count_q == CntW'(ClksPerBit - 1));
  assign half_o     = (count_q == CntW'(half_bit(ClksPerBit) - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control unit. Sequences one frame (start, DATA_BITS data bits LSB first, one
// stop bit) per start_bit_detected pulse and hands the byte to the host via ready/read.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start_bit_detected  : 1-cycle pulse from the start-bit detector, honoured only in IDLE
//   serial_sync         : synchronized serial line
//   data_read           : host consumed rx_data (1-cycle pulse)
//   rx_data             : last good byte received
//   data_ready          : rx_data valid and unread
//   overrun_error       : good byte loaded while the previous one was still unread
//   framing_error       : last frame had a zero stop bit
//   rx_busy             : sequencer not idle
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_bit_detected,
  input  logic                 serial_sync,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);

  rx_state_t              state_q, state_d;
  logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   stop_bit_q, stop_bit_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   data_ready_q, data_ready_d;
  logic                   overrun_q, overrun_d;
  logic                   framing_q, framing_d;

  logic timer_clr, timer_roll, timer_half;

  // Timer restarts on every state entry and is held at zero while idle.
  assign timer_clr = (state_q == IDLE) || (state_q != state_d);

  rx_bit_timer #(
    .ClksPerBit (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (timer_clr),
    .en_i       (1'b1),
    .rollover_o (timer_roll),
    .half_o     (timer_half)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    stop_bit_d   = stop_bit_q;
    rx_data_d    = rx_data_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    framing_d    = framing_q;

    if (data_read) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_bit_detected) begin
          state_d   = START;
          framing_d = 1'b0;
        end
      end
      START: begin
        if (timer_half) begin
          if (!serial_sync) begin
            // Timer clears on entry to DATA, so later rollovers land mid-bit.
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (timer_roll) begin
          shift_d   = {serial_sync, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitCntW'(DATA_BITS - 1)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (timer_roll) begin
          stop_bit_d = serial_sync;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (stop_bit_q) begin
          // A coincident data_read loses to the load: byte stays ready, no overrun.
          rx_data_d    = shift_q;
          data_ready_d = 1'b1;
          overrun_d    = data_ready_q & ~data_read;
        end else begin
          framing_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      stop_bit_q   <= 1'b0;
      rx_data_q    <= '0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      framing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      stop_bit_q   <= stop_bit_d;
      rx_data_q    <= rx_data_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      framing_q    <= framing_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = data_ready_q;
  assign overrun_error = overrun_q;
  assign framing_error = framing_q;
  assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl (CLKS_PER_BIT=10, DATA_BITS=8). The driver computes the
// expected host-visible outputs and the cycle at which the frame ends; the monitor compares
// them whenever rx_busy drops.
module tb_uart_rx_ctrl;

  localparam int unsigned Clks = 10;
  localparam int unsigned Bits = 8;
  localparam int unsigned FrameLat = Clks / 2 + (Bits + 1) * Clks + 2;  // 97
  localparam int unsigned FalseLat = Clks / 2 + 1;                      // 6

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_bit_detected = 1'b0;
  logic serial_sync = 1'b1;
  logic data_read = 1'b0;
  logic [Bits-1:0] rx_data;
  logic data_ready, overrun_error, framing_error, rx_busy;

  uart_rx_ctrl #(
    .CLKS_PER_BIT (Clks),
    .DATA_BITS    (Bits)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start_bit_detected (start_bit_detected),
    .serial_sync        (serial_sync),
    .data_read          (data_read),
    .rx_data            (rx_data),
    .data_ready         (data_ready),
    .overrun_error      (overrun_error),
    .framing_error      (framing_error),
    .rx_busy            (rx_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0]  data;
    logic        ready;
    logic        ovr;
    logic        frm;
    int unsigned at;
  } exp_t;

  exp_t sb_q[$];

  // Host-visible reference state.
  logic [7:0] m_data = '0;
  logic m_ready = 1'b0, m_ovr = 1'b0, m_frm = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, int'(rx_data), 0);
    chk({tag, "_ready"}, int'(data_ready), 0);
    chk({tag, "_overrun"}, int'(overrun_error), 0);
    chk({tag, "_framing"}, int'(framing_error), 0);
    chk({tag, "_busy"}, int'(rx_busy), 0);
  endtask

  // Full frame: 10-cycle start, 8 data bits LSB first, stop bit. Optional data_read in CHECK.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic read_at_check);
    exp_t e;
    if (stop) begin
      m_ovr   = read_at_check ? 1'b0 : m_ready;
      m_ready = 1'b1;
      m_data  = b;
    end
    m_frm = ~stop;
    e = '{data: m_data, ready: m_ready, ovr: m_ovr, frm: m_frm, at: cyc + FrameLat};
    sb_q.push_back(e);
    for (int k = 0; k < int'((Bits + 2) * Clks); k++) begin
      start_bit_detected = (k == 0);
      if (k < int'(Clks)) serial_sync = 1'b0;
      else if (k < int'((Bits + 1) * Clks)) serial_sync = b[(k - int'(Clks)) / int'(Clks)];
      else serial_sync = stop;
      data_read = read_at_check && (k == int'(FrameLat) - 1);
      tick();
    end
    start_bit_detected = 1'b0;
    data_read = 1'b0;
    serial_sync = 1'b1;
  endtask

  // Glitch: line low 3 cycles, then high before the half-bit sample.
  task automatic false_start();
    exp_t e;
    m_frm = 1'b0;
    e = '{data: m_data, ready: m_ready, ovr: m_ovr, frm: m_frm, at: cyc + FalseLat};
    sb_q.push_back(e);
    for (int k = 0; k < 30; k++) begin
      start_bit_detected = (k == 0);
      serial_sync = (k >= 3);
      tick();
    end
    start_bit_detected = 1'b0;
  endtask

  task automatic idle_gap(input int n, input logic rd);
    serial_sync = 1'b1;
    for (int k = 0; k < n; k++) begin
      data_read = rd && (k == 0);
      tick();
    end
    data_read = 1'b0;
    if (rd) begin
      m_ready = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  // Monitor: a frame ends when rx_busy falls outside reset.
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !rx_busy) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_frame_end", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("end_cycle", int'(cyc), int'(e.at));
          chk("rx_data", int'(rx_data), int'(e.data));
          chk("data_ready", int'(data_ready), int'(e.ready));
          chk("overrun_error", int'(overrun_error), int'(e.ovr));
          chk("framing_error", int'(framing_error), int'(e.frm));
        end
      end
      prev_busy = rx_busy;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    idle_gap(12, 1'b0);

    // Good frame, latency and data.
    send_frame(8'hA5, 1'b1, 1'b0);
    idle_gap(20, 1'b1);
    chk("read_clears_ready", int'(data_ready), 0);

    false_start();
    idle_gap(10, 1'b0);

    // Bad stop bit keeps previous data.
    send_frame(8'h3C, 1'b0, 1'b0);
    idle_gap(15, 1'b0);

    // Overrun, then read clears both flags.
    send_frame(8'h11, 1'b1, 1'b0);
    idle_gap(12, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle_gap(12, 1'b0);
    idle_gap(5, 1'b1);
    chk("read_clears_ready2", int'(data_ready), 0);
    chk("read_clears_overrun", int'(overrun_error), 0);

    // Read coinciding with a good load: load wins.
    send_frame(8'h66, 1'b1, 1'b0);
    idle_gap(12, 1'b0);
    send_frame(8'h77, 1'b1, 1'b1);
    idle_gap(12, 1'b0);

    // Reset in the middle of DATA.
    for (int k = 0; k < 45; k++) begin
      start_bit_detected = (k == 0);
      serial_sync = (k < 10) ? 1'b0 : k[0];
      tick();
    end
    start_bit_detected = 1'b0;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    m_data = '0;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    m_frm = 1'b0;
    serial_sync = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle_gap(15, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle_gap(15, 1'b0);

    // Randomized mix.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      logic stop, rac;
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        false_start();
      end else begin
        stop = ($urandom_range(0, 3) != 0);
        rac  = stop && ($urandom_range(0, 2) == 0);
        send_frame(b, stop, rac);
      end
      idle_gap(10 + int'($urandom_range(0, 19)), 1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
